// File: rtl/result_argmax.sv
// Argmax over one inference's class scores, buffered then scanned.
// Optional feature: RESULT_STREAM_EN streams buffer entries during the scan.
module result_argmax #(
    parameter int DATA_W    = 16,
    parameter int NUM_CLASS = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chip_en,
    input  logic              result_write_en,
    input  logic              result_read_en,
    input  logic [DATA_W-1:0] score_in,
    output logic [3:0]        class_idx,
    output logic [DATA_W-1:0] max_score,
    output logic              class_valid,
    output logic              ovf_err,
    output logic              abort_err,
    output logic [DATA_W-1:0] score_out,
    output logic              score_out_valid
);

    localparam int CW = $clog2(NUM_CLASS + 1);
    localparam int IW = $clog2(NUM_CLASS);
    localparam logic [CW-1:0] NC  = CW'(NUM_CLASS);
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        WAIT,
        SCAN,
        DONE
    } state_t;

    state_t state;

    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_idx;

    logic signed [DATA_W-1:0] score_buf [NUM_CLASS];
    logic signed [DATA_W-1:0] best;
    logic signed [DATA_W-1:0] cand;
    logic signed [DATA_W-1:0] win_score;
    logic [3:0]               best_idx;
    logic [3:0]               win_idx;

    logic          wr_en;
    logic [IW-1:0] wr_addr;

    // Strictly-greater replacement keeps the lowest index on ties
    always_comb begin
        cand      = score_buf[rd_idx[IW-1:0]];
        win_score = best;
        win_idx   = best_idx;
        if (cand > best) begin
            win_score = cand;
            win_idx   = 4'(rd_idx);
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        if (chip_en && result_write_en) begin
            if (state == IDLE) begin
                wr_en = 1'b1;
            end else if (state == CAPTURE && wr_cnt < NC) begin
                wr_en   = 1'b1;
                wr_addr = wr_cnt[IW-1:0];
            end
        end
    end

    // Buffer contents are don't-care after reset, so no reset here
    always_ff @(posedge clk) begin
        if (wr_en) begin
            score_buf[wr_addr] <= score_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wr_cnt      <= '0;
            rd_idx      <= '0;
            best        <= '0;
            best_idx    <= '0;
            class_idx   <= '0;
            max_score   <= '0;
            class_valid <= 1'b0;
            ovf_err     <= 1'b0;
            abort_err   <= 1'b0;
        end else if (!chip_en) begin
            state       <= IDLE;
            wr_cnt      <= '0;
            rd_idx      <= '0;
            class_valid <= 1'b0;
            ovf_err     <= 1'b0;
            abort_err   <= 1'b0;
        end else begin
            class_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (result_write_en) begin
                        wr_cnt <= ONE;
                        state  <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (result_write_en) begin
                        if (wr_cnt < NC) wr_cnt <= wr_cnt + ONE;
                        else             ovf_err <= 1'b1;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (result_read_en) begin
                        best     <= score_buf[0];
                        best_idx <= '0;
                        rd_idx   <= ONE;
                        if (wr_cnt == ONE) begin
                            state       <= DONE;
                            class_idx   <= '0;
                            max_score   <= score_buf[0];
                            class_valid <= 1'b1;
                        end else begin
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (result_read_en) begin
                        best     <= win_score;
                        best_idx <= win_idx;
                        if (rd_idx == wr_cnt - ONE) begin
                            state       <= DONE;
                            class_idx   <= win_idx;
                            max_score   <= win_score;
                            class_valid <= 1'b1;
                        end else begin
                            rd_idx <= rd_idx + ONE;
                        end
                    end else begin
                        abort_err <= 1'b1;
                        state     <= IDLE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RESULT_STREAM_EN
    // Each edge emits the entry it consumes, so the stream lags by one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            score_out       <= '0;
            score_out_valid <= 1'b0;
        end else if (chip_en && result_read_en && state == WAIT) begin
            score_out       <= score_buf[0];
            score_out_valid <= 1'b1;
        end else if (chip_en && result_read_en && state == SCAN) begin
            score_out       <= cand;
            score_out_valid <= 1'b1;
        end else begin
            score_out       <= '0;
            score_out_valid <= 1'b0;
        end
    end
`else
    assign score_out       = '0;
    assign score_out_valid = 1'b0;
`endif

endmodule

// File: doc/result_argmax.md
RESULT_ARGMAX -- requirements
Module: result_argmax

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of one signed class score.
REQ-002 SHALL have parameter NUM_CLASS, default 10: number of class scores per inference, in the range 2..16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port chip_en, input, 1 bit: inference enable from the sequencer.
REQ-006 SHALL have port result_write_en, input, 1 bit: result-buffer write window from the sequencer.
REQ-007 SHALL have port result_read_en, input, 1 bit: result-buffer read/scan window from the sequencer.
REQ-008 SHALL have port score_in, input, DATA_W bits: signed two's-complement score from the fully-connected stage.
REQ-009 SHALL have port class_idx, output, 4 bits: index of the winning class.
REQ-010 SHALL have port max_score, output, DATA_W bits: score of the winning class.
REQ-011 SHALL have port class_valid, output, 1 bit: one-cycle pulse marking a new result.
REQ-012 SHALL have port ovf_err, output, 1 bit: sticky flag; more than NUM_CLASS write cycles seen.
REQ-013 SHALL have port abort_err, output, 1 bit: sticky flag; read window ended before the scan completed.
REQ-014 SHALL have port score_out, output, DATA_W bits: streamed buffer entry (see REQ-030).
REQ-015 SHALL have port score_out_valid, output, 1 bit: qualifier for score_out.

Function
REQ-016 SHALL implement states IDLE, CAPTURE, WAIT, SCAN and DONE, with a NUM_CLASS x DATA_W buffer, a write counter wr_cnt and a read index rd_idx.
REQ-017 SHALL, in IDLE with chip_en=1 and result_write_en=1, store score_in to buf[0], set wr_cnt=1 and enter CAPTURE.
REQ-018 SHALL, in CAPTURE with result_write_en=1 and wr_cnt<NUM_CLASS, store buf[wr_cnt] and increment wr_cnt.
REQ-019 SHALL, in CAPTURE with result_write_en=1 and wr_cnt==NUM_CLASS, discard score_in and set ovf_err.
REQ-020 SHALL, in CAPTURE with result_write_en=0, enter WAIT.
REQ-021 SHALL, on the first edge in WAIT with result_read_en=1, load best=buf[0], set idx 0 and rd_idx=1, and then enter SCAN; if wr_cnt==1 it SHALL enter DONE instead.
REQ-022 SHALL, in SCAN with result_read_en=1, compare buf[rd_idx] against best using a signed comparison, replacing best only on strictly greater, so that ties keep the lowest index.
REQ-023 SHALL, in SCAN, enter DONE on the edge that processes entry wr_cnt-1 and register class_idx and max_score on that same edge.
REQ-024 SHALL assert class_valid for exactly one cycle, the cycle in DONE; DONE SHALL then return to IDLE.
REQ-025 SHALL achieve the following latency with wr_cnt=10: class_valid high in the cycle after the 10th consecutive edge sampling result_read_en=1.
REQ-026 SHALL, in SCAN with result_read_en=0, set abort_err, return to IDLE, leave class_idx and max_score unchanged, and not pulse class_valid.
REQ-027 SHALL ignore result_read_en in IDLE and CAPTURE, and ignore result_write_en in WAIT, SCAN and DONE.
REQ-028 SHALL, on any edge with chip_en=0, force IDLE and clear wr_cnt, rd_idx, class_valid, ovf_err and abort_err; class_idx and max_score SHALL be retained.
REQ-029 SHALL hold class_idx and max_score stable between class_valid pulses.

Configuration
REQ-030 SHALL implement macro RESULT_STREAM_EN: when defined, score_out=buf[rd_idx-1] and score_out_valid=1 on each SCAN/DONE cycle, registered and aligned with processing; when undefined, score_out and score_out_valid SHALL be tied to 0 and no streaming logic instantiated.

Reset
REQ-031 SHALL, on reset=0 and regardless of clk, set state=IDLE, wr_cnt=0, rd_idx=0, class_idx=0, max_score=0, class_valid=0, ovf_err=0, abort_err=0, score_out=0 and score_out_valid=0.
REQ-032 SHALL, on reset asserted mid-CAPTURE or mid-SCAN, abort the operation with no class_valid pulse; buffer contents are don't-care.

Verification
REQ-033 SHALL verify nominal operation: 10 writes {3,-1,7,2,7,0,-5,1,6,4}, then 14 read cycles -> class_idx=2, max_score=7, exactly one class_valid pulse, 10 cycles after read start.
REQ-034 SHALL verify negative scores: all writes negative {-9,-3,-8,-3,...} -> class_idx=1, max_score=-3.
REQ-035 SHALL verify overflow: 14 write cycles (as the sequencer issues) -> first 10 captured, ovf_err=1, and the argmax over entries 0..9 only.
REQ-036 SHALL verify abort: result_read_en dropped after 5 cycles -> abort_err=1, no class_valid, and class_idx holding its prior value.
REQ-037 SHALL verify reset and chip_en clearing: reset low mid-SCAN -> all outputs 0; chip_en low in WAIT -> IDLE with flags cleared and class_idx retained.
REQ-038 SHALL verify RESULT_STREAM_EN: with the macro defined, score_out emits entries 0..9 in order with score_out_valid high; with it undefined, both outputs stay 0.
